// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised general/scratch register file:
// function-select codes and the select-index to enable-bit mapping.
package regfile_pkg;

  localparam logic [2:0] FS_DEC      = 3'b000;
  localparam logic [2:0] FS_INC      = 3'b001;
  localparam logic [2:0] FS_LOAD     = 3'b010;
  localparam logic [2:0] FS_CLR      = 3'b011;
  localparam logic [2:0] FS_LOADLO_Z = 3'b100;
  localparam logic [2:0] FS_LOADLO_K = 3'b101;
  localparam logic [2:0] FS_LOADHI_K = 3'b110;
  localparam logic [2:0] FS_SEXT     = 3'b111;

  // With enables concatenated as {RegSel, ScrSel}, select index k (R1 = 0,
  // then Rn, S1..Sn) lives at bit n-1-k of the n-bit concatenation.
  function automatic int en_bit(input int k, input int n);
    return n - 1 - k;
  endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Bus between the ALU/memory data path and the register file: write data,
// function select, active-low enables, read selects and the read results.
interface regfile_param_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int NSCR  = 4
);
  localparam int SELW = $clog2(NREG + NSCR);

  // No handshake: every edge with an enable bit low is a write of FunSel/I
  // into that register; OutA/OutB/Wrap are always valid (no ready/stall).
  logic [WIDTH-1:0]     I;
  logic [2:0]           FunSel;
  logic [NREG-1:0]      RegSel;
  logic [NSCR-1:0]      ScrSel;
  logic [SELW-1:0]      OutASel;
  logic [SELW-1:0]      OutBSel;
  logic                 WrapClr;
  logic [WIDTH-1:0]     OutA;
  logic [WIDTH-1:0]     OutB;
  logic [NREG+NSCR-1:0] Wrap;

  modport master (
    output I, FunSel, RegSel, ScrSel, OutASel, OutBSel, WrapClr,
    input  OutA, OutB, Wrap
  );

  modport slave (
    input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel, WrapClr,
    output OutA, OutB, Wrap
  );

endinterface

// File: rtl/gpr_cell.sv
// One register of the file with its sticky wrap flag; Qnext is the value
// this edge will write (equal to Q when the cell is not enabled).
module gpr_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic             WrapClr,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap,
  output logic [WIDTH-1:0] Qnext
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             wrap_set;

  always_comb begin
    q_d = q_q;
    if (!E) begin
      case (FunSel)
        FS_DEC:      q_d = q_q - WIDTH'(1);
        FS_INC:      q_d = q_q + WIDTH'(1);
        FS_LOAD:     q_d = I;
        FS_CLR:      q_d = '0;
        FS_LOADLO_Z: q_d = {{(WIDTH-H){1'b0}}, I[H-1:0]};
        FS_LOADLO_K: q_d = {q_q[WIDTH-1:H], I[H-1:0]};
        FS_LOADHI_K: q_d = {I[H-1:0], q_q[H-1:0]};
        default:     q_d = {{(WIDTH-H){I[H-1]}}, I[H-1:0]};
      endcase
    end
  end

  // Setting a wrap in the same cycle as WrapClr keeps the flag set.
  always_comb begin
    wrap_set = !E && (((FunSel == FS_INC) && (&q_q)) ||
                      ((FunSel == FS_DEC) && (q_q == '0)));
    wrap_d   = wrap_set || (wrap_q && !WrapClr);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q     = q_q;
  assign Wrap  = wrap_q;
  assign Qnext = q_d;

endmodule

// File: rtl/regfile_param.sv
// NREG general plus NSCR scratch registers sharing one function select,
// with two read ports that are either combinational or registered.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int NREG    = 4,
  parameter  int NSCR    = 4,
  parameter  int OUT_REG = 0,
  parameter  int BYPASS  = 1,
  localparam int SELW    = $clog2(NREG + NSCR)
) (
  input logic             Clock,
  input logic             Reset,
  regfile_param_if.slave  bus
);

  localparam int N = NREG + NSCR;
  localparam bit USE_NEXT = (OUT_REG != 0) && (BYPASS != 0);

  logic [N-1:0]     en_n;
  logic [WIDTH-1:0] q   [N];
  logic [WIDTH-1:0] qn  [N];
  logic [N-1:0]     wrap;
  logic [WIDTH-1:0] rd_a, rd_b;

  assign en_n = {bus.RegSel, bus.ScrSel};

  for (genvar k = 0; k < N; k++) begin : g_cell
    localparam int EB = en_bit(k, N);
    gpr_cell #(.WIDTH(WIDTH)) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .I      (bus.I),
      .E      (en_n[EB]),
      .FunSel (bus.FunSel),
      .WrapClr(bus.WrapClr),
      .Q      (q[k]),
      .Wrap   (wrap[k]),
      .Qnext  (qn[k])
    );
  end

  assign bus.Wrap = wrap;

  // Selects past the last register fall through to zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.OutASel == SELW'(k)) rd_a = USE_NEXT ? qn[k] : q[k];
      if (bus.OutBSel == SELW'(k)) rd_b = USE_NEXT ? qn[k] : q[k];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] out_a_q, out_b_q;

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        out_a_q <= '0;
        out_b_q <= '0;
      end else begin
        out_a_q <= rd_a;
        out_b_q <= rd_b;
      end
    end

    assign bus.OutA = out_a_q;
    assign bus.OutB = out_b_q;
  end else begin : g_out_comb
    assign bus.OutA = rd_a;
    assign bus.OutB = rd_b;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: four configurations driven side by side and
// compared each cycle against a behavioural model of the register file.
module tb_regfile_param;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  regfile_param_if #(.WIDTH(16), .NREG(4), .NSCR(4)) ifa ();
  regfile_param_if #(.WIDTH(16), .NREG(4), .NSCR(4)) ifb ();
  regfile_param_if #(.WIDTH(16), .NREG(4), .NSCR(4)) ifc ();
  regfile_param_if #(.WIDTH(16), .NREG(3), .NSCR(2)) ifd ();

  regfile_param #(.WIDTH(16), .NREG(4), .NSCR(4), .OUT_REG(0), .BYPASS(1))
    u_a (.Clock(clk), .Reset(rst_n), .bus(ifa.slave));
  regfile_param #(.WIDTH(16), .NREG(4), .NSCR(4), .OUT_REG(1), .BYPASS(1))
    u_b (.Clock(clk), .Reset(rst_n), .bus(ifb.slave));
  regfile_param #(.WIDTH(16), .NREG(4), .NSCR(4), .OUT_REG(1), .BYPASS(0))
    u_c (.Clock(clk), .Reset(rst_n), .bus(ifc.slave));
  regfile_param #(.WIDTH(16), .NREG(3), .NSCR(2), .OUT_REG(0), .BYPASS(1))
    u_d (.Clock(clk), .Reset(rst_n), .bus(ifd.slave));

  // Stimulus for the three 4+4 instances (shared) and the 3+2 instance
  logic [15:0] t_i;  logic [2:0] t_fs;  logic [3:0] t_rs, t_ss;
  logic [2:0]  t_as, t_bs;  logic t_wc;
  logic [15:0] d_i;  logic [2:0] d_fs;  logic [2:0] d_rs;  logic [1:0] d_ss;
  logic [2:0]  d_as, d_bs;  logic d_wc;

  always_comb begin
    ifa.I = t_i; ifa.FunSel = t_fs; ifa.RegSel = t_rs; ifa.ScrSel = t_ss;
    ifa.OutASel = t_as; ifa.OutBSel = t_bs; ifa.WrapClr = t_wc;
    ifb.I = t_i; ifb.FunSel = t_fs; ifb.RegSel = t_rs; ifb.ScrSel = t_ss;
    ifb.OutASel = t_as; ifb.OutBSel = t_bs; ifb.WrapClr = t_wc;
    ifc.I = t_i; ifc.FunSel = t_fs; ifc.RegSel = t_rs; ifc.ScrSel = t_ss;
    ifc.OutASel = t_as; ifc.OutBSel = t_bs; ifc.WrapClr = t_wc;
    ifd.I = d_i; ifd.FunSel = d_fs; ifd.RegSel = d_rs; ifd.ScrSel = d_ss;
    ifd.OutASel = d_as; ifd.OutBSel = d_bs; ifd.WrapClr = d_wc;
  end

  // Reference model state
  logic [15:0] m_q [8];
  logic [7:0]  m_w;
  logic [15:0] m_ba, m_bb, m_ca, m_cb;
  logic [15:0] d_q [5];
  logic [4:0]  d_w;

  function automatic logic [15:0] f_apply(input logic [2:0] fs,
                                          input logic [15:0] q,
                                          input logic [15:0] i);
    case (fs)
      3'd0:    return q - 16'd1;
      3'd1:    return q + 16'd1;
      3'd2:    return i;
      3'd3:    return 16'd0;
      3'd4:    return i & 16'h00FF;
      3'd5:    return (q & 16'hFF00) | (i & 16'h00FF);
      3'd6:    return ((i & 16'h00FF) << 8) | (q & 16'h00FF);
      default: return i[7] ? (i | 16'hFF00) : (i & 16'h00FF);
    endcase
  endfunction

  function automatic bit f_wraps(input logic [2:0] fs, input logic [15:0] q);
    return (fs == 3'd1 && q == 16'hFFFF) || (fs == 3'd0 && q == 16'h0000);
  endfunction

  function automatic logic [15:0] d_rd(input logic [2:0] sel);
    return (sel < 3'd5) ? d_q[sel] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_q[k] = '0;
    for (int k = 0; k < 5; k++) d_q[k] = '0;
    m_w = '0; d_w = '0;
    m_ba = '0; m_bb = '0; m_ca = '0; m_cb = '0;
  endtask

  task automatic set_idle();
    t_fs = 3'd2; t_i = 16'($urandom); t_rs = 4'hF; t_ss = 4'hF; t_wc = 1'b0;
    d_fs = 3'd2; d_i = 16'($urandom); d_rs = 3'h7; d_ss = 2'h3; d_wc = 1'b0;
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    logic [15:0] nq [8];
    logic [7:0]  nw;
    logic [15:0] dnq [5];
    logic [4:0]  dnw;
    bit en;
    #1;
    chk("a_outa_pre", ifa.OutA, m_q[t_as]);
    chk("a_outb_pre", ifa.OutB, m_q[t_bs]);
    chk("d_outa_pre", ifd.OutA, d_rd(d_as));
    for (int k = 0; k < 8; k++) begin
      en = (k < 4) ? (t_rs[3-k] == 1'b0) : (t_ss[7-k] == 1'b0);
      nq[k] = en ? f_apply(t_fs, m_q[k], t_i) : m_q[k];
      nw[k] = (en && f_wraps(t_fs, m_q[k])) || (m_w[k] && !t_wc);
    end
    for (int k = 0; k < 5; k++) begin
      en = (k < 3) ? (d_rs[2-k] == 1'b0) : (d_ss[4-k] == 1'b0);
      dnq[k] = en ? f_apply(d_fs, d_q[k], d_i) : d_q[k];
      dnw[k] = (en && f_wraps(d_fs, d_q[k])) || (d_w[k] && !d_wc);
    end
    m_ba = nq[t_as];  m_bb = nq[t_bs];
    m_ca = m_q[t_as]; m_cb = m_q[t_bs];
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) m_q[k] = nq[k];
    for (int k = 0; k < 5; k++) d_q[k] = dnq[k];
    m_w = nw; d_w = dnw;
    chk("a_outa", ifa.OutA, m_q[t_as]);
    chk("a_outb", ifa.OutB, m_q[t_bs]);
    chk("a_wrap", ifa.Wrap, m_w);
    chk("b_outa", ifb.OutA, m_ba);
    chk("b_outb", ifb.OutB, m_bb);
    chk("b_wrap", ifb.Wrap, m_w);
    chk("c_outa", ifc.OutA, m_ca);
    chk("c_outb", ifc.OutB, m_cb);
    chk("c_wrap", ifc.Wrap, m_w);
    chk("d_outa", ifd.OutA, d_rd(d_as));
    chk("d_outb", ifd.OutB, d_rd(d_bs));
    chk("d_wrap", ifd.Wrap, d_w);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outa"}, ifa.OutA, 16'h0);
    chk({tag, "_a_outb"}, ifa.OutB, 16'h0);
    chk({tag, "_a_wrap"}, ifa.Wrap, 8'h0);
    chk({tag, "_b_outa"}, ifb.OutA, 16'h0);
    chk({tag, "_c_outb"}, ifc.OutB, 16'h0);
    chk({tag, "_d_outa"}, ifd.OutA, 16'h0);
    chk({tag, "_d_wrap"}, ifd.Wrap, 5'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    t_as = 3'd0; t_bs = 3'd1; d_as = 3'd0; d_bs = 3'd1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // R1 load only
    t_fs = 3'd2; t_i = 16'h1234; t_rs = 4'b0111; t_as = 3'd0; t_bs = 3'd1;
    cycle();
    chk("tp2_r1", ifa.OutA, 16'h1234);
    chk("tp2_r2", ifa.OutB, 16'h0000);

    // S2 wrap on INC, then set-over-clear
    set_idle();
    t_fs = 3'd2; t_i = 16'hFFFF; t_ss = 4'b1011; t_as = 3'd5;
    cycle();
    t_fs = 3'd1;
    cycle();
    chk("tp3_s2", ifa.OutA, 16'h0000);
    chk("tp3_wrap", ifa.Wrap[5], 1'b1);
    t_fs = 3'd2;
    cycle();
    t_fs = 3'd1; t_wc = 1'b1;
    cycle();
    chk("tp3_wrap_sticky", ifa.Wrap[5], 1'b1);

    // Half-word modes on R3
    set_idle();
    t_rs = 4'b1101; t_as = 3'd2;
    t_fs = 3'd2; t_i = 16'h12FF; cycle();
    t_fs = 3'd5; t_i = 16'h00AB; cycle();
    chk("tp4_lolk", ifa.OutA, 16'h12AB);
    t_fs = 3'd6; t_i = 16'h00CD; cycle();
    chk("tp4_hik", ifa.OutA, 16'hCDAB);
    t_fs = 3'd7; t_i = 16'h0080; cycle();
    chk("tp4_sext", ifa.OutA, 16'hFF80);

    // Registered ports with and without bypass on R2
    set_idle();
    t_rs = 4'b1011; t_fs = 3'd2; t_i = 16'd5; t_bs = 3'd1;
    cycle();
    t_fs = 3'd0;
    cycle();
    chk("tp5_byp", ifb.OutB, 16'd4);
    chk("tp5_nobyp", ifc.OutB, 16'd5);
    set_idle();
    cycle();
    chk("tp5_nobyp_late", ifc.OutB, 16'd4);

    // Out-of-range selects and all-ones enables on the 3+2 file
    set_idle();
    d_rs = 3'b011; d_fs = 3'd2; d_i = 16'hBEEF; d_as = 3'd0;
    cycle();
    for (int s = 5; s < 8; s++) begin
      set_idle();
      d_as = 3'(s);
      cycle();
      chk("tp6_oor", ifd.OutA, 16'h0000);
    end
    set_idle();
    d_fs = 3'd2; d_i = 16'hDEAD; d_as = 3'd0; d_bs = 3'd3;
    cycle();
    chk("tp6_hold_r1", ifd.OutA, 16'hBEEF);
    chk("tp6_hold_s1", ifd.OutB, 16'h0000);

    // Everything loaded, then reset asynchronously mid-cycle
    t_fs = 3'd2; t_i = 16'hA5A5; t_rs = 4'h0; t_ss = 4'h0; t_as = 3'd3; t_bs = 3'd6;
    d_fs = 3'd2; d_i = 16'hA5A5; d_rs = 3'h0; d_ss = 2'h0; d_as = 3'd1; d_bs = 3'd4;
    cycle();
    chk("tp1_loaded", ifa.OutA, 16'hA5A5);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("tp1_async");
    model_reset();
    set_idle();
    @(posedge clk);
    #1;
    chk_all_zero("tp1_hold");
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      t_fs = 3'($urandom_range(0, 7)); t_i = 16'($urandom);
      t_rs = 4'($urandom); t_ss = 4'($urandom);
      t_as = 3'($urandom_range(0, 7)); t_bs = 3'($urandom_range(0, 7));
      t_wc = ($urandom_range(0, 7) == 0);
      d_fs = 3'($urandom_range(0, 7)); d_i = 16'($urandom);
      d_rs = 3'($urandom); d_ss = 2'($urandom);
      d_as = 3'($urandom_range(0, 7)); d_bs = 3'($urandom_range(0, 7));
      d_wc = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the 8-entry general/scratch register file. It holds NREG general registers (R1..Rn) and NSCR scratch registers (S1..Sn), all WIDTH bits wide. Each register has a shared 3-bit function select with half-word load modes and sticky per-register wrap flags. It drives two read ports that are combinational or registered, selected by parameter, with optional write bypass. It sits between the ALU/memory data bus and the ALU operand muxes.

Parameters:
WIDTH, 16, register width in bits; must be even and >= 4.
NREG, 4, number of general registers (1..8).
NSCR, 4, number of scratch registers (1..8).
OUT_REG, 0, 0 = combinational read ports; 1 = registered read ports with 1-cycle latency.
BYPASS, 1, applies only when OUT_REG=1; 1 = the output register captures the post-write value of the selected register.
SELW, $clog2(NREG+NSCR), read-select width; derived, not overridden.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
I  in  WIDTH  write data
FunSel  in  3  function applied to every enabled register
RegSel  in  NREG  active-low enables; bit NREG-1 = R1 ... bit 0 = Rn
ScrSel  in  NSCR  active-low enables; bit NSCR-1 = S1 ... bit 0 = Sn
OutASel  in  SELW  port A select: 0..NREG-1 = R1..Rn; NREG..NREG+NSCR-1 = S1..Sn
OutBSel  in  SELW  port B select, same mapping
WrapClr  in  1  synchronous clear of all wrap flags
OutA  out  WIDTH  port A data
OutB  out  WIDTH  port B data
Wrap  out  NREG+NSCR  sticky wrap flags; bit k corresponds to select index k

Behaviour:
- Reset low, asynchronously:
  - all registers = 0;
  - Wrap = 0;
  - the OUT_REG=1 output registers = 0.
  - With OUT_REG=0, OutA and OutB are therefore 0.
- Reset is released synchronously to Clock by the integrator; the block itself does not synchronise it.
- A register updates on the rising edge only when its enable bit is 0. Multiple registers may be enabled in one cycle; all apply the same FunSel to the same I.
- FunSel codes (H = WIDTH/2):
  - 000 DEC: Q-1, modulo 2^WIDTH.
  - 001 INC: Q+1, modulo 2^WIDTH.
  - 010 LOAD: Q = I.
  - 011 CLEAR: Q = 0.
  - 100 LOADLO_Z: Q = {0, I[H-1:0]}.
  - 101 LOADLO_K: Q = {Q[WIDTH-1:H], I[H-1:0]}.
  - 110 LOADHI_K: Q = {I[H-1:0], Q[H-1:0]}.
  - 111 SEXT: Q = sign-extended I[H-1:0].
- Wrap flag of register k:
  - Set on an edge where the register is enabled and either INC with Q = all-ones or DEC with Q = 0.
  - Cleared on an edge where WrapClr = 1.
  - Set wins over clear in the same cycle.
  - Holds otherwise.
- Read selects ≥ NREG+NSCR (possible when the total is not a power of 2) return 0.
- Read ports with OUT_REG=0:
  - purely combinational from the current register Q; no clock latency.
  - Same-cycle write and read: the read returns the old value until the edge.
- Read ports with OUT_REG=1:
  - the output register samples on each rising edge.
  - BYPASS=0: it captures the pre-edge Q (old value).
  - BYPASS=1: it captures the value being written this edge, if the selected register is enabled, else Q.
- OutA and OutB are independent and may select the same register.
- All-ones RegSel/ScrSel: no register change; wrap flags change only via WrapClr.

Decomposition:
- Shared package/header regfile_pkg holds:
  - FunSel code localparams: FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LOADLO_Z, FS_LOADLO_K, FS_LOADHI_K, FS_SEXT;
  - the select-index mapping helper.
- Sub-module gpr_cell holds one register plus its wrap flag:
  - inputs: I, E (active-low), FunSel, WrapClr, Clock, Reset;
  - outputs: Q, Wrap, Qnext;
  - Qnext feeds the bypass path.
- The top level instantiates NREG+NSCR cells in a generate loop and two read muxes.

Test Plan:
1. Reset low mid-cycle with all registers loaded 16'hA5A5 -> immediately all Q = 0, Wrap = 0, OutA = OutB = 0 with no clock edge.
2. LOAD 16'h1234 with RegSel=4'b0111 (R1 only), OutASel=0, OUT_REG=0 -> OutA = 16'h1234 after the edge, other registers still 0.
3. S2 = 16'hFFFF, INC with ScrSel=4'b1011 -> S2 = 0 and Wrap[5] = 1; WrapClr=1 with a simultaneous INC wrapping S2 again -> Wrap[5] stays 1.
4. R3 = 16'h12FF: LOADLO_K with I = 16'h00AB gives 16'h12AB; then LOADHI_K with I = 16'h00CD gives 16'hCDAB; then SEXT with I = 16'h0080 gives 16'hFF80.
5. OUT_REG=1, BYPASS=1, R2 = 5, DEC on R2 with OutBSel=1 -> OutB = 4 one edge later; same with BYPASS=0 -> OutB = 5, then 4 on the following edge.
6. NREG=3, NSCR=2 (SELW=3), OutASel = 5, 6, 7 -> OutA = 0; RegSel = all-ones with LOAD -> no register changes.
